// File: rtl/pcie_us_axi_master_cq_demux.sv
// Routes the UltraScale PCIe CQ stream to the AXI master write or read engine.
// Unsupported request types are swallowed and flagged as uncorrectable errors.
module pcie_us_axi_master_cq_demux #(
  parameter int AXIS_PCIE_DATA_WIDTH    = 512,
  parameter int AXIS_PCIE_KEEP_WIDTH    = AXIS_PCIE_DATA_WIDTH/32,
  parameter int AXIS_PCIE_CQ_USER_WIDTH = 183,
  parameter int COUNT_WIDTH             = 16
) (
  input  logic                               clk,
  input  logic                               rst,

  input  logic [AXIS_PCIE_DATA_WIDTH-1:0]    s_axis_cq_tdata,
  input  logic [AXIS_PCIE_KEEP_WIDTH-1:0]    s_axis_cq_tkeep,
  input  logic                               s_axis_cq_tvalid,
  output logic                               s_axis_cq_tready,
  input  logic                               s_axis_cq_tlast,
  input  logic [AXIS_PCIE_CQ_USER_WIDTH-1:0] s_axis_cq_tuser,

  output logic [AXIS_PCIE_DATA_WIDTH-1:0]    m_axis_cq_wr_tdata,
  output logic [AXIS_PCIE_KEEP_WIDTH-1:0]    m_axis_cq_wr_tkeep,
  output logic                               m_axis_cq_wr_tvalid,
  input  logic                               m_axis_cq_wr_tready,
  output logic                               m_axis_cq_wr_tlast,
  output logic [AXIS_PCIE_CQ_USER_WIDTH-1:0] m_axis_cq_wr_tuser,

  output logic [AXIS_PCIE_DATA_WIDTH-1:0]    m_axis_cq_rd_tdata,
  output logic [AXIS_PCIE_KEEP_WIDTH-1:0]    m_axis_cq_rd_tkeep,
  output logic                               m_axis_cq_rd_tvalid,
  input  logic                               m_axis_cq_rd_tready,
  output logic                               m_axis_cq_rd_tlast,
  output logic [AXIS_PCIE_CQ_USER_WIDTH-1:0] m_axis_cq_rd_tuser,

  input  logic                               enable,

  output logic                               status_error_uncor,
  output logic [COUNT_WIDTH-1:0]             status_wr_count,
  output logic [COUNT_WIDTH-1:0]             status_rd_count,
  output logic [COUNT_WIDTH-1:0]             status_drop_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FWD_WR = 2'd1,
    FWD_RD = 2'd2,
    DROP   = 2'd3
  } state_t;

  localparam logic [3:0] REQ_MEM_RD = 4'b0000;
  localparam logic [3:0] REQ_MEM_WR = 4'b0001;

  state_t     state, state_next;
  logic [3:0] req_type;
  logic       first_wr, first_rd, first_drop;

  assign req_type = s_axis_cq_tdata[78:75];

  // Payload sidebands fan out unchanged; only the handshake is steered.
  assign m_axis_cq_wr_tdata = s_axis_cq_tdata;
  assign m_axis_cq_wr_tkeep = s_axis_cq_tkeep;
  assign m_axis_cq_wr_tlast = s_axis_cq_tlast;
  assign m_axis_cq_wr_tuser = s_axis_cq_tuser;
  assign m_axis_cq_rd_tdata = s_axis_cq_tdata;
  assign m_axis_cq_rd_tkeep = s_axis_cq_tkeep;
  assign m_axis_cq_rd_tlast = s_axis_cq_tlast;
  assign m_axis_cq_rd_tuser = s_axis_cq_tuser;

  // Reset forces the handshake closed combinationally so nothing leaks during rst.
  always_comb begin
    state_next          = state;
    s_axis_cq_tready    = 1'b0;
    m_axis_cq_wr_tvalid = 1'b0;
    m_axis_cq_rd_tvalid = 1'b0;
    first_wr            = 1'b0;
    first_rd            = 1'b0;
    first_drop          = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (enable && s_axis_cq_tvalid) begin
            if (req_type == REQ_MEM_WR) begin
              m_axis_cq_wr_tvalid = 1'b1;
              s_axis_cq_tready    = m_axis_cq_wr_tready;
              if (m_axis_cq_wr_tready) begin
                first_wr = 1'b1;
                if (!s_axis_cq_tlast) state_next = FWD_WR;
              end
            end else if (req_type == REQ_MEM_RD) begin
              m_axis_cq_rd_tvalid = 1'b1;
              s_axis_cq_tready    = m_axis_cq_rd_tready;
              if (m_axis_cq_rd_tready) begin
                first_rd = 1'b1;
                if (!s_axis_cq_tlast) state_next = FWD_RD;
              end
            end else begin
              s_axis_cq_tready = 1'b1;
              first_drop       = 1'b1;
              if (!s_axis_cq_tlast) state_next = DROP;
            end
          end
        end
        FWD_WR: begin
          m_axis_cq_wr_tvalid = s_axis_cq_tvalid;
          s_axis_cq_tready    = m_axis_cq_wr_tready;
          if (s_axis_cq_tvalid && m_axis_cq_wr_tready && s_axis_cq_tlast) state_next = IDLE;
        end
        FWD_RD: begin
          m_axis_cq_rd_tvalid = s_axis_cq_tvalid;
          s_axis_cq_tready    = m_axis_cq_rd_tready;
          if (s_axis_cq_tvalid && m_axis_cq_rd_tready && s_axis_cq_tlast) state_next = IDLE;
        end
        DROP: begin
          s_axis_cq_tready = 1'b1;
          if (s_axis_cq_tvalid && s_axis_cq_tlast) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Counters bump on the header handshake only, so multi-beat packets count once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      status_error_uncor <= 1'b0;
      status_wr_count    <= '0;
      status_rd_count    <= '0;
      status_drop_count  <= '0;
    end else begin
      state              <= state_next;
      status_error_uncor <= first_drop;
      if (first_wr)   status_wr_count   <= status_wr_count + 1'b1;
      if (first_rd)   status_rd_count   <= status_rd_count + 1'b1;
      if (first_drop) status_drop_count <= status_drop_count + 1'b1;
    end
  end

endmodule
